// File: rtl/uart_pkg.sv
// Shared types and limits for the UART receive controller.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START_CHK,
    DATA,
    PARITY,
    STOP,
    LOAD
  } rx_state_t;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 9;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

endpackage

// File: rtl/rx_shift_reg.sv
// LSB-first receive shift register: new bits enter at the MSB and move down.
module rx_shift_reg #(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 shift_en,
  input  logic                 din,
  output logic [DATA_BITS-1:0] dout
);

  always_ff @(posedge clk) begin
    if (shift_en) dout <= {din, dout[DATA_BITS-1:1]};
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start confirmation, data, optional parity, stop bits,
// output buffer and error flags.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_bit_detected,
  input  logic                 bit_strobe,
  input  logic                 rx_bit,
  input  logic                 data_read,
  output logic                 enable_timer,
  output logic                 timer_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 data_ready,
  output logic                 framing_error,
  output logic                 parity_error,
  output logic                 overrun_error
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_BITS - 1);
  localparam logic [1:0]       LAST_STOP = 2'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_bad_data_bits
    $error("uart_rx_ctrl: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_bad_stop_bits
    $error("uart_rx_ctrl: STOP_BITS must be in 1..2");
  end

  rx_state_t            state;
  logic [CNT_W-1:0]     bit_cnt;
  logic [1:0]           stop_cnt;
  logic                 parity_acc;
  logic                 par_bad;
  logic                 stop_bad;
  logic                 shift_en;
  logic [DATA_BITS-1:0] shift_data;

  assign shift_en = (state == DATA) && bit_strobe;

  rx_shift_reg #(.DATA_BITS(DATA_BITS)) u_shift (
    .clk      (clk),
    .shift_en (shift_en),
    .din      (rx_bit),
    .dout     (shift_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      enable_timer  <= 1'b0;
      timer_clear   <= 1'b0;
      rx_data       <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      parity_error  <= 1'b0;
      overrun_error <= 1'b0;
      bit_cnt       <= '0;
      stop_cnt      <= '0;
      parity_acc    <= 1'b0;
      par_bad       <= 1'b0;
      stop_bad      <= 1'b0;
    end else begin
      timer_clear <= 1'b0;
      if (data_read) begin
        data_ready    <= 1'b0;
        overrun_error <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start_bit_detected) begin
            state        <= START_CHK;
            timer_clear  <= 1'b1;
            enable_timer <= 1'b1;
            stop_bad     <= 1'b0;
            par_bad      <= 1'b0;
            parity_acc   <= 1'b0;
          end
        end
        START_CHK: begin
          if (bit_strobe) begin
            if (!rx_bit) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              // Line went back high at mid-bit: glitch, not a frame.
              state        <= IDLE;
              enable_timer <= 1'b0;
            end
          end
        end
        DATA: begin
          if (bit_strobe) begin
            parity_acc <= parity_acc ^ rx_bit;
            bit_cnt    <= bit_cnt + 1'b1;
            if (bit_cnt == LAST_DATA) begin
              stop_cnt <= '0;
              state    <= (PARITY_EN != 0) ? PARITY : STOP;
            end
          end
        end
        PARITY: begin
          if (bit_strobe) begin
            par_bad <= parity_acc ^ rx_bit ^ ODD;
            state   <= STOP;
          end
        end
        STOP: begin
          if (bit_strobe) begin
            if (!rx_bit) stop_bad <= 1'b1;
            stop_cnt <= stop_cnt + 1'b1;
            if (stop_cnt == LAST_STOP) begin
              state        <= LOAD;
              enable_timer <= 1'b0;
            end
          end
        end
        LOAD: begin
          framing_error <= stop_bad;
          if (!stop_bad) begin
            rx_data       <= shift_data;
            parity_error  <= par_bad;
            data_ready    <= 1'b1;
            // A read landing in this same cycle consumes the old frame, so no overrun.
            overrun_error <= (overrun_error | data_ready) & ~data_read;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: an 8N1 instance (u0) and a 7E2 instance (u1).
module tb_uart_rx_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic sbd[2];
  logic stb[2];
  logic rxb[2];
  logic rd[2];
  logic en[2];
  logic tc[2];
  logic dr[2];
  logic fe[2];
  logic pe[2];
  logic oe[2];
  logic [7:0] rxd0;
  logic [6:0] rxd1;

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst),
    .start_bit_detected(sbd[0]), .bit_strobe(stb[0]), .rx_bit(rxb[0]), .data_read(rd[0]),
    .enable_timer(en[0]), .timer_clear(tc[0]), .rx_data(rxd0), .data_ready(dr[0]),
    .framing_error(fe[0]), .parity_error(pe[0]), .overrun_error(oe[0])
  );

  uart_rx_ctrl #(.DATA_BITS(7), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst),
    .start_bit_detected(sbd[1]), .bit_strobe(stb[1]), .rx_bit(rxb[1]), .data_read(rd[1]),
    .enable_timer(en[1]), .timer_clear(tc[1]), .rx_data(rxd1), .data_ready(dr[1]),
    .framing_error(fe[1]), .parity_error(pe[1]), .overrun_error(oe[1])
  );

  int nvec = 0;
  int nerr = 0;
  int en_cnt = 0;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    bit         read_before;
    logic [7:0] exp_rx;
    logic       exp_dr;
    logic       exp_fe;
    logic       exp_pe;
    logic       exp_oe;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input int i, input logic b);
    repeat (2) tick();
    rxb[i] = b;
    stb[i] = 1'b1;
    if (en[i] === 1'b1) en_cnt++;
    tick();
    stb[i] = 1'b0;
  endtask

  task automatic pulse_read(input int i);
    rd[i] = 1'b1;
    tick();
    rd[i] = 1'b0;
  endtask

  // Full frame; returns two edges after the last stop strobe (LOAD has completed).
  task automatic send_frame(input int i, input logic [8:0] d, input int nb, input bit pen,
                            input logic pb, input int ns, input logic sv, input bit rd_load);
    sbd[i] = 1'b1;
    tick();
    sbd[i] = 1'b0;
    send_bit(i, 1'b0);
    for (int k = 0; k < nb; k++) send_bit(i, d[k]);
    if (pen) send_bit(i, pb);
    for (int k = 0; k < ns; k++) send_bit(i, sv);
    if (rd_load) rd[i] = 1'b1;
    tick();
    rd[i] = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      sbd[i] = 1'b0; stb[i] = 1'b0; rxb[i] = 1'b1; rd[i] = 1'b0;
    end

    tbl[0] = '{8'hA5, 1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{8'h12, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 1'b0, 1'b0};

    repeat (3) tick();
    rst = 1'b0;
    tick();

    chk("reset enable_timer", 32'(en[0]), 0);
    chk("reset timer_clear", 32'(tc[0]), 0);
    chk("reset rx_data", 32'(rxd0), 0);
    chk("reset data_ready", 32'(dr[0]), 0);
    chk("reset framing_error", 32'(fe[0]), 0);
    chk("reset parity_error", 32'(pe[0]), 0);
    chk("reset overrun_error", 32'(oe[0]), 0);
    chk("reset u1 rx_data", 32'(rxd1), 0);

    // Table-driven 8N1 frames.
    for (int v = 0; v < 6; v++) begin
      if (tbl[v].read_before) pulse_read(0);
      if (v == 0) en_cnt = 0;
      send_frame(0, {1'b0, tbl[v].data}, 8, 1'b0, 1'b0, 1, tbl[v].stop, 1'b0);
      if (v == 0) chk("8N1 enable_timer strobes", en_cnt, 10);
      chk($sformatf("v%0d rx_data", v), 32'(rxd0), 32'(tbl[v].exp_rx));
      chk($sformatf("v%0d data_ready", v), 32'(dr[0]), 32'(tbl[v].exp_dr));
      chk($sformatf("v%0d framing_error", v), 32'(fe[0]), 32'(tbl[v].exp_fe));
      chk($sformatf("v%0d parity_error", v), 32'(pe[0]), 32'(tbl[v].exp_pe));
      chk($sformatf("v%0d overrun_error", v), 32'(oe[0]), 32'(tbl[v].exp_oe));
      chk($sformatf("v%0d enable_timer idle", v), 32'(en[0]), 0);
    end

    // Read coinciding with the second frame's LOAD: no overrun.
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    send_frame(0, 9'h022, 8, 1'b0, 1'b0, 1, 1'b1, 1'b1);
    chk("load-read rx_data", 32'(rxd0), 32'h22);
    chk("load-read data_ready", 32'(dr[0]), 1);
    chk("load-read overrun_error", 32'(oe[0]), 0);

    // False start.
    sbd[0] = 1'b1;
    tick();
    sbd[0] = 1'b0;
    chk("false start timer_clear", 32'(tc[0]), 1);
    chk("false start enable_timer on", 32'(en[0]), 1);
    tick();
    chk("timer_clear one cycle", 32'(tc[0]), 0);
    send_bit(0, 1'b1);
    chk("false start enable_timer off", 32'(en[0]), 0);
    tick();
    chk("false start rx_data", 32'(rxd0), 32'h22);
    chk("false start data_ready", 32'(dr[0]), 1);
    chk("false start framing_error", 32'(fe[0]), 0);
    chk("false start overrun_error", 32'(oe[0]), 0);

    // Reset during the 4th data strobe.
    sbd[0] = 1'b1;
    tick();
    sbd[0] = 1'b0;
    send_bit(0, 1'b0);
    for (int k = 0; k < 3; k++) send_bit(0, 1'b1);
    repeat (2) tick();
    rxb[0] = 1'b1;
    stb[0] = 1'b1;
    rst = 1'b1;
    #1;
    chk("midreset enable_timer", 32'(en[0]), 0);
    chk("midreset rx_data", 32'(rxd0), 0);
    chk("midreset data_ready", 32'(dr[0]), 0);
    chk("midreset framing_error", 32'(fe[0]), 0);
    chk("midreset overrun_error", 32'(oe[0]), 0);
    tick();
    stb[0] = 1'b0;
    rst = 1'b0;
    tick();
    en_cnt = 0;
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1, 1'b1, 1'b0);
    chk("post-reset rx_data", 32'(rxd0), 32'h3C);
    chk("post-reset data_ready", 32'(dr[0]), 1);
    chk("post-reset overrun_error", 32'(oe[0]), 0);
    chk("post-reset strobes", en_cnt, 10);

    // 7E2: wrong parity then a good frame.
    en_cnt = 0;
    send_frame(1, 9'h055, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    chk("7E2 strobes", en_cnt, 11);
    chk("7E2 bad rx_data", 32'(rxd1), 32'h55);
    chk("7E2 bad parity_error", 32'(pe[1]), 1);
    chk("7E2 bad data_ready", 32'(dr[1]), 1);
    chk("7E2 bad framing_error", 32'(fe[1]), 0);
    pulse_read(1);
    send_frame(1, 9'h02A, 7, 1'b1, 1'b1, 2, 1'b1, 1'b0);
    chk("7E2 good rx_data", 32'(rxd1), 32'h2A);
    chk("7E2 good parity_error", 32'(pe[1]), 0);
    chk("7E2 good overrun_error", 32'(oe[1]), 0);
    // Second stop bit low is a framing error even with the first stop bit high.
    sbd[1] = 1'b1;
    tick();
    sbd[1] = 1'b0;
    send_bit(1, 1'b0);
    for (int k = 0; k < 7; k++) send_bit(1, 1'b0);
    send_bit(1, 1'b0);
    send_bit(1, 1'b1);
    send_bit(1, 1'b0);
    repeat (2) tick();
    chk("7E2 stop2 framing_error", 32'(fe[1]), 1);
    chk("7E2 stop2 rx_data kept", 32'(rxd1), 32'h2A);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
